// File: rtl/timer_display.sv
// Countdown-timer display reader: mm:ss to BCD by repeated subtraction,
// then a time-multiplexed 4-digit seven-segment driver with blink.
module timer_display #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] time_in,
    input  logic        time_up,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t state, state_n;

    logic [11:0]   shadow;
    logic [5:0]    m_v, s_v;
    logic [3:0]    mt, st;
    logic [3:0]    dig [4];
    logic          load, step, commit;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic [3:0]    cur;

    function automatic logic [6:0] decode(input logic [3:0] d);
        unique case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (time_in != shadow) begin
                    load    = 1'b1;
                    state_n = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (m_v < 6'd10 && s_v < 6'd10) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Conversion datapath; input changes during CONV wait for the next IDLE compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            m_v    <= '0;
            s_v    <= '0;
            mt     <= '0;
            st     <= '0;
            dig[0] <= '0;
            dig[1] <= '0;
            dig[2] <= '0;
            dig[3] <= '0;
        end else if (load) begin
            shadow <= time_in;
            m_v    <= time_in[11:6];
            s_v    <= time_in[5:0];
            mt     <= '0;
            st     <= '0;
        end else if (step) begin
            if (m_v >= 6'd10) begin
                m_v <= m_v - 6'd10;
                mt  <= mt + 4'd1;
            end
            if (s_v >= 6'd10) begin
                s_v <= s_v - 6'd10;
                st  <= st + 4'd1;
            end
        end else if (commit) begin
            dig[0] <= s_v[3:0];
            dig[1] <= st;
            dig[2] <= m_v[3:0];
            dig[3] <= mt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !time_up) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign cur = dig[idx];

    always_ff @(posedge clk) begin
        if (rst || blink_ph) begin
            an  <= '0;
            seg <= '0;
            dp  <= 1'b0;
        end else begin
            an  <= 4'b0001 << idx;
            seg <= decode(cur);
            dp  <= (idx == 2'd2);
        end
    end

endmodule

// File: tb/tb_timer_display.sv
// Randomized bench for timer_display against an arithmetic reference model
// (digits by /10 and %10, scan and blink phase from elapsed cycle counts).
module tb_timer_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] time_in = '0;
    logic        time_up = 1'b0;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    timer_display #(
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .time_in(time_in),
        .time_up(time_up),
        .busy   (busy),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state
    int         left;
    int         n_cyc;
    int         up_cnt;
    int         mdig [4];
    logic [11:0] shadow_m;
    logic [11:0] pend;
    logic       e_busy;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    always @(posedge clk) begin
        int mi, se, ix;
        if (rst) begin
            e_an = '0; e_seg = '0; e_dp = 1'b0;
            left = 0; n_cyc = 0; up_cnt = 0;
            shadow_m = '0; pend = '0;
            for (int i = 0; i < 4; i++) mdig[i] = 0;
        end else begin
            ix = (n_cyc / SCAN_DIV) % 4;
            if (((up_cnt / BLINK_DIV) % 2) == 1) begin
                e_an = '0; e_seg = '0; e_dp = 1'b0;
            end else begin
                e_an  = 4'(1 << ix);
                e_seg = (mdig[ix] < 10) ? segtab[mdig[ix]] : 7'h00;
                e_dp  = (ix == 2);
            end
            n_cyc++;
            up_cnt = time_up ? up_cnt + 1 : 0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    mi = int'(pend[11:6]);
                    se = int'(pend[5:0]);
                    mdig[0] = se % 10;
                    mdig[1] = se / 10;
                    mdig[2] = mi % 10;
                    mdig[3] = mi / 10;
                end
            end else if (time_in != shadow_m) begin
                shadow_m = time_in;
                pend = time_in;
                mi = int'(time_in[11:6]);
                se = int'(time_in[5:0]);
                left = ((mi / 10 > se / 10) ? mi / 10 : se / 10) + 1;
            end
        end
        e_busy = (left > 0);
    end

    task automatic cycle_chk();
        @(negedge clk);
        chk("busy", 12'(busy), 12'(e_busy));
        chk("an",   12'(an),   12'(e_an));
        chk("seg",  12'(seg),  12'(e_seg));
        chk("dp",   12'(dp),   12'(e_dp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_chk();
    endtask

    initial begin
        int busy_len;
        run(2);
        chk("rst_an", 12'(an), 12'h0);
        rst = 1'b0;
        cycle_chk();
        chk("post_rst_an", 12'(an), 12'h1);
        chk("post_rst_seg", 12'(seg), 12'h3F);

        time_in = 12'h15D;
        busy_len = 0;
        for (int i = 0; i < 12; i++) begin
            cycle_chk();
            if (busy) busy_len++;
        end
        chk("busy_len_0529", 12'(busy_len), 12'd3);
        run(20);

        time_in = 12'hFFB;
        busy_len = 0;
        for (int i = 0; i < 12; i++) begin
            cycle_chk();
            if (busy) busy_len++;
        end
        chk("busy_len_6359", 12'(busy_len), 12'd7);
        run(20);

        time_in = 12'h15D;
        cycle_chk();
        time_in = 12'h03C;
        run(30);

        time_up = 1'b1;
        run(40);
        time_up = 1'b0;
        run(20);

        time_in = 12'hFFB;
        run(2);
        rst = 1'b1;
        cycle_chk();
        chk("mid_rst_busy", 12'(busy), 12'h0);
        rst = 1'b0;
        run(30);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) time_in = 12'($urandom);
            if ($urandom_range(0, 29) == 0) time_up = ~time_up;
            rst = ($urandom_range(0, 199) == 0);
            cycle_chk();
        end
        rst = 1'b0;
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
